// File: rtl/booth_issue_ctrl_if.sv
// rtl/booth_issue_ctrl_if.sv - operand, multiplier and result handshake bundle for booth_issue_ctrl
interface booth_issue_ctrl_if #(
    parameter int width = 16
);
    logic               in_valid;
    logic               in_ready;
    logic [width-1:0]   in_mcand;
    logic [width-1:0]   in_mplier;
    logic               mul_Begin;
    logic [width-1:0]   mul_Multiplicand;
    logic [width-1:0]   mul_Multiplier;
    logic               mul_End;
    logic [2*width-1:0] mul_Product;
    logic               out_valid;
    logic               out_ready;
    logic [2*width-1:0] out_product;

    modport master (
        output in_valid, in_mcand, in_mplier,
        input  in_ready,
        input  mul_Begin, mul_Multiplicand, mul_Multiplier,
        output mul_End, mul_Product,
        input  out_valid, out_product,
        output out_ready
    );

    modport slave (
        input  in_valid, in_mcand, in_mplier,
        output in_ready,
        output mul_Begin, mul_Multiplicand, mul_Multiplier,
        input  mul_End, mul_Product,
        output out_valid, out_product,
        input  out_ready
    );
endinterface

// File: rtl/booth_issue_ctrl.sv
// rtl/booth_issue_ctrl.sv - operand FIFO, one-at-a-time Booth multiplier issue and result register with watchdog
module booth_issue_ctrl #(
    parameter int width   = 16,
    parameter int DEPTH   = 2,
    parameter int TIMEOUT = 2*width+8
) (
    input  logic              CLK,
    input  logic              CLR,
    booth_issue_ctrl_if.slave bus,
    output logic              busy,
    output logic              err
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH+1);
    localparam int WW = $clog2(TIMEOUT+1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_HOLD  = 2'd3;

    logic [1:0]         state;
    logic [width-1:0]   fifo_mcand  [DEPTH];
    logic [width-1:0]   fifo_mplier [DEPTH];
    logic [PW-1:0]      wr_ptr;
    logic [PW-1:0]      rd_ptr;
    logic [CW-1:0]      count;
    logic [width-1:0]   mcand_q;
    logic [width-1:0]   mplier_q;
    logic [WW-1:0]      wdog;
    logic               out_valid_q;
    logic [2*width-1:0] out_product_q;
    logic               push;
    logic               pop;
    logic               slot_free;
    logic               capture;

    // No pass-through: a full FIFO refuses even when the head pops this cycle
    assign bus.in_ready = (count != CW'(DEPTH)) && !CLR;
    assign push         = bus.in_valid && bus.in_ready;
    assign pop          = (state == S_IDLE) && (count != '0);
    assign slot_free    = !out_valid_q || bus.out_ready;
    assign capture      = slot_free && (((state == S_WAIT) && bus.mul_End) || (state == S_HOLD));

    assign bus.mul_Begin        = (state == S_START);
    assign bus.mul_Multiplicand = mcand_q;
    assign bus.mul_Multiplier   = mplier_q;
    assign bus.out_valid        = out_valid_q;
    assign bus.out_product      = out_product_q;
    assign busy                 = (state != S_IDLE) || (count != '0);

    always_ff @(posedge CLK) begin
        if (push) begin
            fifo_mcand[wr_ptr]  <= bus.in_mcand;
            fifo_mplier[wr_ptr] <= bus.in_mplier;
        end
    end

    always_ff @(posedge CLK) begin
        if (CLR) begin
            state         <= S_IDLE;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            mcand_q       <= '0;
            mplier_q      <= '0;
            wdog          <= '0;
            out_valid_q   <= 1'b0;
            out_product_q <= '0;
            err           <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            if (push && !pop)      count <= count + CW'(1);
            else if (pop && !push) count <= count - CW'(1);

            // A capture on a draining edge keeps out_valid high with the new product
            if (capture) begin
                out_valid_q   <= 1'b1;
                out_product_q <= bus.mul_Product;
            end else if (bus.out_ready) begin
                out_valid_q   <= 1'b0;
            end

            case (state)
                S_IDLE: begin
                    if (pop) begin
                        mcand_q  <= fifo_mcand[rd_ptr];
                        mplier_q <= fifo_mplier[rd_ptr];
                        state    <= S_START;
                    end
                end
                S_START: begin
                    wdog  <= '0;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (bus.mul_End) begin
                        state <= capture ? S_IDLE : S_HOLD;
                    end else if (wdog == WW'(TIMEOUT-1)) begin
                        err   <= 1'b1;
                        state <= S_IDLE;
                    end else begin
                        wdog  <= wdog + WW'(1);
                    end
                end
                S_HOLD: begin
                    // The multiplier keeps Product stable until the next Begin
                    if (capture) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_booth_issue_ctrl.sv
// tb/tb_booth_issue_ctrl.sv - directed and randomized checks of booth_issue_ctrl against a queue-based model
module tb_booth_issue_ctrl;
    localparam int W   = 16;
    localparam int TMO = 2*W+8;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        int           lat;
        bit           hang;
    } op_t;

    logic CLK = 1'b0;
    logic CLR;
    logic busy;
    logic err;
    int   total = 0;
    int   bad   = 0;

    booth_issue_ctrl_if #(.width(W)) bus();

    booth_issue_ctrl #(.width(W), .DEPTH(2), .TIMEOUT(TMO)) dut (
        .CLK  (CLK),
        .CLR  (CLR),
        .bus  (bus),
        .busy (busy),
        .err  (err)
    );

    always #5 CLK = ~CLK;

    op_t            issue_q[$];
    logic [2*W-1:0] res_q[$];
    op_t            mo;
    int             cur_lat = 2;
    bit             cur_hang = 1'b0;
    int             nxt_lat = 2;
    bit             nxt_hang = 1'b0;
    int             begins = 0;
    int             results = 0;
    bit             prev_hold = 1'b0;
    logic [2*W-1:0] prev_prod = '0;
    bit             rand_rdy = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Multiplier model: End rises lat cycles after Begin, held with Product until the next Begin
    logic           m_end = 1'b0;
    logic [2*W-1:0] m_prod = '0;
    int             mdl_cnt = 0;
    int             ma;
    int             mb;
    assign bus.mul_End     = m_end;
    assign bus.mul_Product = m_prod;

    always @(posedge CLK) begin
        if (bus.mul_Begin === 1'b1) begin
            ma = int'($signed(bus.mul_Multiplicand));
            mb = int'($signed(bus.mul_Multiplier));
            m_end   <= 1'b0;
            m_prod  <= 32'(ma * mb);
            mdl_cnt <= nxt_hang ? 0 : nxt_lat - 1;
        end else if (mdl_cnt == 1) begin
            m_end   <= 1'b1;
            mdl_cnt <= 0;
        end else if (mdl_cnt > 1) begin
            mdl_cnt <= mdl_cnt - 1;
        end
    end

    // Scoreboard: operands issue in acceptance order, results emerge in issue order minus hung ops
    always @(negedge CLK) begin
        if (CLR) begin
            issue_q.delete();
            res_q.delete();
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) begin
                chk("hold_valid", 64'(bus.out_valid), 64'(1'b1));
                chk("hold_data", 64'(bus.out_product), 64'(prev_prod));
            end
            if (bus.mul_Begin) begin
                begins++;
                chk("begin_has_op", 64'(issue_q.size() != 0), 64'(1'b1));
                if (issue_q.size() != 0) begin
                    mo = issue_q.pop_front();
                    chk("issue_mcand", 64'(bus.mul_Multiplicand), 64'(mo.a));
                    chk("issue_mplier", 64'(bus.mul_Multiplier), 64'(mo.b));
                    nxt_lat  = mo.lat;
                    nxt_hang = mo.hang;
                    if (!mo.hang) res_q.push_back(32'(int'($signed(mo.a)) * int'($signed(mo.b))));
                end
            end
            if (bus.in_valid && bus.in_ready)
                issue_q.push_back('{bus.in_mcand, bus.in_mplier, cur_lat, cur_hang});
            if (bus.out_valid && bus.out_ready) begin
                results++;
                chk("result_has_ref", 64'(res_q.size() != 0), 64'(1'b1));
                if (res_q.size() != 0) chk("result_data", 64'(bus.out_product), 64'(res_q.pop_front()));
            end
            prev_hold = bus.out_valid && !bus.out_ready;
            prev_prod = bus.out_product;
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
        if (rand_rdy) bus.out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input int lat, input bit hang);
        int n = 0;
        bus.in_valid = 1'b1;
        bus.in_mcand = a;
        bus.in_mplier = b;
        cur_lat  = lat;
        cur_hang = hang;
        @(negedge CLK);
        while (!bus.in_ready && n < 300) begin
            tick();
            @(negedge CLK);
            n++;
        end
        chk("send_accepted", 64'(bus.in_ready), 64'(1'b1));
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_begin(input int lim);
        int n = 0;
        @(negedge CLK);
        while (!bus.mul_Begin && n < lim) begin
            tick();
            @(negedge CLK);
            n++;
        end
        chk("begin_seen", 64'(bus.mul_Begin), 64'(1'b1));
    endtask

    task automatic wait_out_valid(input int lim);
        int n = 0;
        @(negedge CLK);
        while (!bus.out_valid && n < lim) begin
            tick();
            @(negedge CLK);
            n++;
        end
        chk("out_valid_seen", 64'(bus.out_valid), 64'(1'b1));
    endtask

    task automatic wait_idle(input int lim);
        int n = 0;
        @(negedge CLK);
        while ((busy || bus.out_valid) && n < lim) begin
            tick();
            @(negedge CLK);
            n++;
        end
        chk("idle_reached", 64'(busy || bus.out_valid), 64'(1'b0));
        chk("results_all_out", 64'(res_q.size()), 64'(0));
    endtask

    task automatic check_cleared(input string tag);
        chk({tag, "_in_ready"}, 64'(bus.in_ready), 64'(1'b1));
        chk({tag, "_out_valid"}, 64'(bus.out_valid), 64'(1'b0));
        chk({tag, "_out_product"}, 64'(bus.out_product), 64'(0));
        chk({tag, "_begin"}, 64'(bus.mul_Begin), 64'(1'b0));
        chk({tag, "_mcand"}, 64'(bus.mul_Multiplicand), 64'(0));
        chk({tag, "_mplier"}, 64'(bus.mul_Multiplier), 64'(0));
        chk({tag, "_busy"}, 64'(busy), 64'(1'b0));
        chk({tag, "_err"}, 64'(err), 64'(1'b0));
    endtask

    initial begin
        int b0;
        int r0;
        int n;
        bit any_hang;
        logic [W-1:0] ra;
        logic [W-1:0] rb;

        bus.in_valid = 1'b0;
        bus.in_mcand = '0;
        bus.in_mplier = '0;
        bus.out_ready = 1'b0;
        CLR = 1'b1;
        tick();
        tick();
        @(negedge CLK);
        chk("ready_during_clr", 64'(bus.in_ready), 64'(1'b0));
        tick();
        CLR = 1'b0;
        @(negedge CLK);
        check_cleared("reset");

        // Single op 3 x -5, multiplier latency 18
        tick();
        send(16'd3, 16'hFFFB, 18, 1'b0);
        wait_begin(5);
        n = 0;
        while (!bus.out_valid && n < 40) begin
            @(negedge CLK);
            n++;
        end
        chk("single_latency", 64'(n), 64'(19));
        chk("single_product", 64'(bus.out_product), 64'(32'hFFFFFFF1));
        chk("single_begins", 64'(begins), 64'(1));
        repeat (4) tick();
        bus.out_ready = 1'b1;
        tick();
        @(negedge CLK);
        chk("single_drained", 64'(bus.out_valid), 64'(1'b0));

        // FIFO fills while the multiplier is busy
        b0 = begins;
        tick();
        send(16'd100, 16'd200, 15, 1'b0);
        wait_begin(5);
        tick();
        send(16'hFFFF, 16'd7, 4, 1'b0);
        send(16'd1234, 16'h8001, 4, 1'b0);
        bus.in_valid = 1'b1;
        bus.in_mcand = 16'd9;
        bus.in_mplier = 16'd11;
        cur_lat = 4;
        cur_hang = 1'b0;
        @(negedge CLK);
        chk("fifo_full_ready", 64'(bus.in_ready), 64'(1'b0));
        send(16'd9, 16'd11, 4, 1'b0);
        wait_idle(300);
        chk("fifo_begins", 64'(begins - b0), 64'(4));

        // Output backpressure across two completions
        b0 = begins;
        r0 = results;
        tick();
        bus.out_ready = 1'b0;
        send(16'd21, 16'd2, 5, 1'b0);
        send(16'hFFF0, 16'hFFF0, 5, 1'b0);
        send(16'd5, 16'd6, 5, 1'b0);
        repeat (60) tick();
        @(negedge CLK);
        chk("bp_begins_withheld", 64'(begins - b0), 64'(2));
        chk("bp_out_valid", 64'(bus.out_valid), 64'(1'b1));
        chk("bp_busy", 64'(busy), 64'(1'b1));
        tick();
        bus.out_ready = 1'b1;
        wait_idle(200);
        chk("bp_begins", 64'(begins - b0), 64'(3));
        chk("bp_results", 64'(results - r0), 64'(3));

        // Watchdog timeout, then a corner-case operand pair
        r0 = results;
        tick();
        send(16'd1, 16'd2, 5, 1'b1);
        wait_begin(5);
        repeat (TMO) @(negedge CLK);
        chk("tmo_err_early", 64'(err), 64'(1'b0));
        @(negedge CLK);
        chk("tmo_err_set", 64'(err), 64'(1'b1));
        chk("tmo_idle", 64'(busy), 64'(1'b0));
        chk("tmo_no_result", 64'(results - r0), 64'(0));
        tick();
        send(16'h8000, 16'h8000, 7, 1'b0);
        wait_out_valid(40);
        chk("tmo_next_product", 64'(bus.out_product), 64'(32'h40000000));
        chk("tmo_err_sticky", 64'(err), 64'(1'b1));
        wait_idle(50);

        // Drain and capture on the same edge
        tick();
        bus.out_ready = 1'b0;
        send(16'd7, 16'd9, 3, 1'b0);
        wait_out_valid(30);
        tick();
        send(16'hFFFE, 16'd1000, 6, 1'b0);
        wait_begin(5);
        repeat (6) @(posedge CLK);
        #1;
        bus.out_ready = 1'b1;
        @(negedge CLK);
        chk("sim_old_valid", 64'(bus.out_valid), 64'(1'b1));
        chk("sim_old_product", 64'(bus.out_product), 64'(32'd63));
        @(negedge CLK);
        chk("sim_new_valid", 64'(bus.out_valid), 64'(1'b1));
        chk("sim_new_product", 64'(bus.out_product), 64'(32'hFFFFF830));
        wait_idle(20);

        // Reset mid-WAIT with one entry queued; the late End must be ignored
        tick();
        send(16'd5, 16'd5, 20, 1'b0);
        wait_begin(5);
        tick();
        send(16'd6, 16'd6, 4, 1'b0);
        repeat (3) tick();
        CLR = 1'b1;
        tick();
        CLR = 1'b0;
        b0 = begins;
        @(negedge CLK);
        check_cleared("midclr");
        n = 0;
        repeat (30) begin
            @(negedge CLK);
            if (bus.out_valid) n++;
        end
        chk("midclr_late_end_ignored", 64'(n), 64'(0));
        chk("midclr_no_begin", 64'(begins - b0), 64'(0));

        // Randomized traffic with random output backpressure
        any_hang = 1'b0;
        rand_rdy = 1'b1;
        for (int i = 0; i < 40; i++) begin
            bit h;
            h  = ($urandom_range(0, 11) == 0);
            ra = ($urandom_range(0, 5) == 0) ? 16'h8000 : 16'($urandom_range(0, 65535));
            rb = ($urandom_range(0, 5) == 0) ? 16'h7FFF : 16'($urandom_range(0, 65535));
            any_hang |= h;
            repeat ($urandom_range(0, 3)) tick();
            send(ra, rb, $urandom_range(2, 20), h);
        end
        wait_idle(3000);
        rand_rdy = 1'b0;
        chk("rand_issue_q_empty", 64'(issue_q.size()), 64'(0));
        chk("rand_err", 64'(err), 64'(any_hang));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
